// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared USRT types, constants and parity helper
//
// Purpose: FSM state encoding, data-width limits and parity-select constants
//          shared by the USRT Rx/Tx controllers.
// Ports:   none (package).

package usrt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PARITY  = 3'd2,
        ST_STOP    = 3'd3,
        ST_DELIVER = 3'd4
    } usrt_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;

    localparam logic PAR_SEL_EVEN = 1'b0;
    localparam logic PAR_SEL_ODD  = 1'b1;

    // Expected parity bit: XOR of the data bits, inverted for odd parity.
    // Unused upper bits of the frame must be zero.
    function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data,
                                         input logic                     odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/usrt_sync_edge.sv
// rtl/usrt_sync_edge.sv - Sclk/Rxd synchroniser with Sclk rising-edge tick
//
// Purpose: brings the external bit clock and data line into the i_Pclk
//          domain and emits a one-cycle sample tick per Sclk rising edge.
//          Tick latency from the Sclk edge is SYNC_STAGES+1 cycles.
// Ports:
//   i_Pclk     in   system clock
//   i_Reset_n  in   asynchronous active-low reset
//   i_Sclk     in   external bit clock (asynchronous)
//   i_Rxd      in   serial data (asynchronous)
//   o_Tick     out  one-cycle pulse after a synchronised Sclk 0->1
//   o_Rxd      out  data bit captured from the same stage as the tick

module usrt_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Pclk,
    input  logic i_Reset_n,
    input  logic i_Sclk,
    input  logic i_Rxd,
    output logic o_Tick,
    output logic o_Rxd
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_rxd_sync;
    logic                   r_sclk_prev;
    logic                   r_tick;
    logic                   r_rxd_smp;
    logic                   w_sclk_s;
    logic                   w_rxd_s;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_rxd_s  = r_rxd_sync[SYNC_STAGES-1];

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sclk_sync <= '0;
            r_rxd_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_tick      <= 1'b0;
            r_rxd_smp   <= 1'b0;
        end else begin
            r_sclk_sync[0] <= i_Sclk;
            r_rxd_sync[0]  <= i_Rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_rxd_sync[i]  <= r_rxd_sync[i-1];
            end
            r_sclk_prev <= w_sclk_s;
            // Tick and data are registered together so the consumer sees a
            // data bit that is aligned with the Sclk edge that produced it.
            r_tick      <= w_sclk_s & ~r_sclk_prev;
            r_rxd_smp   <= w_rxd_s;
        end
    end

    assign o_Tick = r_tick;
    assign o_Rxd  = r_rxd_smp;

endmodule

// File: rtl/usrt_rx_ctrl.sv
// rtl/usrt_rx_ctrl.sv - USRT receive sequencer
//
// Purpose: assembles synchronous serial frames (start, data LSB first,
//          optional parity, stop), hands good bytes to the one-byte Rx data
//          register, and keeps sticky error flags plus the interrupt line.
// Ports:
//   i_Pclk, i_Reset_n   clock, asynchronous active-low reset
//   i_En                receiver enable
//   i_Sclk, i_Rxd       external bit clock and serial data
//   i_Rd                CPU read strobe of the data register
//   i_Clr_err           clears sticky error flags
//   i_Rx_ie, i_Err_ie   data-ready / error interrupt enables
//   i_Full              data register full flag
//   o_Push, o_Data      data register write strobe and byte
//   o_Pop               data register pop strobe
//   o_Overrun, o_Frame_err, o_Parity_err   sticky error flags
//   o_Busy              frame in progress
//   o_Irq               registered interrupt

module usrt_rx_ctrl
    import usrt_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter bit PARITY_EN   = 1'b1,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_Pclk,
    input  logic       i_Reset_n,
    input  logic       i_En,
    input  logic       i_Sclk,
    input  logic       i_Rxd,
    input  logic       i_Rd,
    input  logic       i_Clr_err,
    input  logic       i_Rx_ie,
    input  logic       i_Err_ie,
    input  logic       i_Full,
    output logic       o_Push,
    output logic [7:0] o_Data,
    output logic       o_Pop,
    output logic       o_Overrun,
    output logic       o_Frame_err,
    output logic       o_Parity_err,
    output logic       o_Busy,
    output logic       o_Irq
);

    // Out-of-range widths are clamped to the supported range.
    localparam int DB_EFF = (DATA_BITS < DATA_BITS_MIN) ? DATA_BITS_MIN :
                            (DATA_BITS > DATA_BITS_MAX) ? DATA_BITS_MAX : DATA_BITS;
    localparam logic [2:0] LAST_BIT = 3'(DB_EFF - 1);
    localparam logic       PAR_SEL  = PARITY_ODD ? PAR_SEL_ODD : PAR_SEL_EVEN;

    logic        w_tick;
    logic        w_rxd;

    usrt_state_t r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_cnt,   w_cnt_nxt;
    logic        r_bad,   w_bad_nxt;
    logic        r_overrun, r_frame_err, r_parity_err;
    logic        r_irq;
    logic        w_push;
    logic        w_set_ovr, w_set_fe, w_set_pe;

    usrt_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_Pclk    (i_Pclk),
        .i_Reset_n (i_Reset_n),
        .i_Sclk    (i_Sclk),
        .i_Rxd     (i_Rxd),
        .o_Tick    (w_tick),
        .o_Rxd     (w_rxd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_bad_nxt   = r_bad;
        w_push      = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_fe    = 1'b0;
        w_set_pe    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rxd) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                    w_bad_nxt   = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt[r_cnt] = w_rxd;
                    w_cnt_nxt          = r_cnt + 3'd1;
                    if (r_cnt == LAST_BIT) begin
                        w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    if (w_rxd != calc_parity(r_shift, PAR_SEL)) begin
                        w_set_pe  = 1'b1;
                        w_bad_nxt = 1'b1;
                    end
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (!w_rxd) begin
                        w_set_fe  = 1'b1;
                        w_bad_nxt = 1'b1;
                    end
                    w_state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (r_bad) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_Rd) begin
                    // Hold the byte one cycle so the register's pop cannot
                    // clear the full flag of the byte we are about to push.
                    w_state_nxt = ST_DELIVER;
                end else if (i_Full) begin
                    w_set_ovr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Disable aborts whatever is in flight, including a pending delivery.
        if (!i_En) begin
            w_state_nxt = ST_IDLE;
            w_push      = 1'b0;
            w_set_ovr   = 1'b0;
            w_set_fe    = 1'b0;
            w_set_pe    = 1'b0;
        end
    end

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_bad        <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bad        <= w_bad_nxt;
            // A set in the same cycle as a clear wins.
            r_overrun    <= (r_overrun    & ~i_Clr_err) | w_set_ovr;
            r_frame_err  <= (r_frame_err  & ~i_Clr_err) | w_set_fe;
            r_parity_err <= (r_parity_err & ~i_Clr_err) | w_set_pe;
            r_irq        <= (i_Rx_ie & i_Full) |
                            (i_Err_ie & (r_overrun | r_frame_err | r_parity_err));
        end
    end

    assign o_Push       = w_push;
    assign o_Data       = r_shift;
    assign o_Pop        = i_Rd & i_Full;
    assign o_Overrun    = r_overrun;
    assign o_Frame_err  = r_frame_err;
    assign o_Parity_err = r_parity_err;
    assign o_Busy       = (r_state != ST_IDLE);
    assign o_Irq        = r_irq;

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb/tb_usrt_rx_ctrl.sv - self-checking bench for usrt_rx_ctrl

module tb_usrt_rx_ctrl;

    localparam int   DB      = 8;
    localparam logic TB_ODD  = 1'b0;
    localparam int   HALF_P  = 4;

    logic       clk;
    logic       rst_n;
    logic       i_En, i_Sclk, i_Rxd, i_Rd, i_Clr_err, i_Rx_ie, i_Err_ie, i_Full;
    logic       o_Push, o_Pop, o_Overrun, o_Frame_err, o_Parity_err, o_Busy, o_Irq;
    logic [7:0] o_Data;

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       full;
        logic       exp_push;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    usrt_rx_ctrl #(
        .DATA_BITS   (DB),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (TB_ODD),
        .SYNC_STAGES (2)
    ) dut (
        .i_Pclk       (clk),
        .i_Reset_n    (rst_n),
        .i_En         (i_En),
        .i_Sclk       (i_Sclk),
        .i_Rxd        (i_Rxd),
        .i_Rd         (i_Rd),
        .i_Clr_err    (i_Clr_err),
        .i_Rx_ie      (i_Rx_ie),
        .i_Err_ie     (i_Err_ie),
        .i_Full       (i_Full),
        .o_Push       (o_Push),
        .o_Data       (o_Data),
        .o_Pop        (o_Pop),
        .o_Overrun    (o_Overrun),
        .o_Frame_err  (o_Frame_err),
        .o_Parity_err (o_Parity_err),
        .o_Busy       (o_Busy),
        .o_Irq        (o_Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every push must match the oldest expected byte.
    always @(negedge clk) begin
        #3;
        if (o_Push === 1'b1) begin
            n_push++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got data %0h expected no push", o_Data);
            end else begin
                chk("push_data", {24'd0, o_Data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bit period: data set with Sclk low, then Sclk high. Returns on a
    // negedge four cycles after the Sclk rise.
    task automatic send_bit(input logic b);
        i_Sclk = 1'b0;
        i_Rxd  = b;
        repeat (HALF_P) @(negedge clk);
        i_Sclk = 1'b1;
        repeat (HALF_P) @(negedge clk);
    endtask

    // Full frame; on return the DUT is in its first delivery cycle.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        send_bit(1'b0);
        for (int b = 0; b < DB; b++) send_bit(d[b]);
        send_bit(pbit);
        send_bit(sbit);
    endtask

    task automatic idle(input int n);
        i_Sclk = 1'b0;
        i_Rxd  = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_err();
        @(negedge clk);
        i_Clr_err = 1'b1;
        @(negedge clk);
        i_Clr_err = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ TB_ODD;
    endfunction

    initial begin
        int base;
        rst_n = 1'b0; i_En = 1'b1; i_Sclk = 1'b0; i_Rxd = 1'b1; i_Rd = 1'b0;
        i_Clr_err = 1'b0; i_Rx_ie = 1'b0; i_Err_ie = 1'b0; i_Full = 1'b0;

        //            data   flip  stop  full  push  pe    fe    ovr
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_push",  {31'd0, o_Push}, 32'd0);
        chk("rst_pop",   {31'd0, o_Pop}, 32'd0);
        chk("rst_data",  {24'd0, o_Data}, 32'd0);
        chk("rst_flags", {29'd0, o_Overrun, o_Frame_err, o_Parity_err}, 32'd0);
        chk("rst_busy",  {31'd0, o_Busy}, 32'd0);
        chk("rst_irq",   {31'd0, o_Irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 7; i++) begin
            base   = n_push;
            i_Full = vecs[i].full;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, good_par(vecs[i].data) ^ vecs[i].par_flip, vecs[i].stop);
            idle(3);
            chk($sformatf("v%0d_parity_err", i), {31'd0, o_Parity_err}, {31'd0, vecs[i].exp_pe});
            chk($sformatf("v%0d_frame_err", i),  {31'd0, o_Frame_err},  {31'd0, vecs[i].exp_fe});
            chk($sformatf("v%0d_overrun", i),    {31'd0, o_Overrun},    {31'd0, vecs[i].exp_ovr});
            chk($sformatf("v%0d_busy", i),       {31'd0, o_Busy}, 32'd0);
            chk($sformatf("v%0d_push_count", i), n_push - base, {31'd0, vecs[i].exp_push});
            i_Full = 1'b0;
            clr_err();
            chk($sformatf("v%0d_flags_cleared", i),
                {29'd0, o_Overrun, o_Frame_err, o_Parity_err}, 32'd0);
        end

        // Data-ready interrupt follows i_Full with one register stage.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        idle(2);
        i_Rx_ie = 1'b1;
        @(negedge clk); #1;
        chk("irq_rx_not_full", {31'd0, o_Irq}, 32'd0);
        i_Full = 1'b1;
        @(negedge clk); #1;
        chk("irq_rx_full", {31'd0, o_Irq}, 32'd1);
        i_Full = 1'b0; i_Rx_ie = 1'b0;
        idle(2);

        // Overrun raises the error interrupt.
        base   = n_push;
        i_Full = 1'b1;
        send_frame(8'h11, good_par(8'h11), 1'b1);
        idle(2);
        chk("ovr_flag", {31'd0, o_Overrun}, 32'd1);
        chk("ovr_no_push", n_push - base, 32'd0);
        i_Err_ie = 1'b1;
        @(negedge clk); #1;
        chk("irq_err", {31'd0, o_Irq}, 32'd1);
        i_Full = 1'b0;
        clr_err();
        @(negedge clk); #1;
        chk("irq_err_cleared", {31'd0, o_Irq}, 32'd0);
        i_Err_ie = 1'b0;
        idle(2);

        // Read during delivery: pop first, push one cycle later.
        base   = n_push;
        i_Full = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, good_par(8'h11), 1'b1);
        i_Rd = 1'b1;
        #1;
        chk("defer_pop", {31'd0, o_Pop}, 32'd1);
        chk("defer_no_push", {31'd0, o_Push}, 32'd0);
        @(negedge clk);
        i_Rd   = 1'b0;
        i_Full = 1'b0;
        #1;
        chk("defer_push", {31'd0, o_Push}, 32'd1);
        chk("defer_data", {24'd0, o_Data}, 32'h11);
        idle(3);
        chk("defer_no_overrun", {31'd0, o_Overrun}, 32'd0);
        chk("defer_push_count", n_push - base, 32'd1);

        // Enable dropped after four data bits.
        base = n_push;
        send_bit(1'b0);
        for (int b = 0; b < 4; b++) send_bit(b[0]);
        chk("en_busy_before", {31'd0, o_Busy}, 32'd1);
        i_En = 1'b0;
        @(negedge clk); #1;
        chk("en_idle_next", {31'd0, o_Busy}, 32'd0);
        i_En = 1'b1;
        idle(6);
        chk("en_no_push", n_push - base, 32'd0);
        chk("en_flags_kept_clear", {29'd0, o_Overrun, o_Frame_err, o_Parity_err}, 32'd0);

        // Asynchronous reset mid-frame, with a flag and the interrupt set.
        send_frame(8'hA5, ~good_par(8'hA5), 1'b1);
        idle(2);
        i_Err_ie = 1'b1;
        @(negedge clk); #1;
        chk("pre_rst_irq", {31'd0, o_Irq}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("pre_rst_busy", {31'd0, o_Busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, o_Busy}, 32'd0);
        chk("arst_flags", {29'd0, o_Overrun, o_Frame_err, o_Parity_err}, 32'd0);
        chk("arst_irq",   {31'd0, o_Irq}, 32'd0);
        chk("arst_data",  {24'd0, o_Data}, 32'd0);
        chk("arst_push",  {31'd0, o_Push}, 32'd0);
        i_Err_ie = 1'b0;
        i_Sclk   = 1'b0;
        i_Rxd    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        base = n_push;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        idle(3);
        chk("post_rst_push_count", n_push - base, 32'd1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usrt_rx_ctrl.md
Name: usrt_rx_ctrl

Overview:
- Receive-side sequencer for the USRT.
- Samples the synchronous serial line (external bit clock plus data) in the i_Pclk domain and assembles frames.
- Drives the push and pop strobes of the downstream one-byte Rx data register, using that register's full flag.
- Detects overrun, framing and parity errors, and produces the status bits and interrupt seen by the CPU-side register block.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.
- PARITY_EN, 1, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity.
- SYNC_STAGES, 2, flip-flop stages synchronising i_Sclk and i_Rxd.

Ports:
- i_Pclk  in  1  system clock; all logic on the rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_En  in  1  receiver enable.
- i_Sclk  in  1  external USRT bit clock, asynchronous; frequency <= i_Pclk/4.
- i_Rxd  in  1  serial data; sampled on i_Sclk rising edges.
- i_Rd  in  1  one-cycle CPU read strobe of the data register.
- i_Clr_err  in  1  one-cycle strobe; clears sticky error flags.
- i_Rx_ie  in  1  data-ready interrupt enable.
- i_Err_ie  in  1  error interrupt enable.
- i_Full  in  1  full flag from the Rx data register.
- o_Push  out  1  write strobe to the data register.
- o_Data  out  8  assembled byte; bits above DATA_BITS are 0.
- o_Pop  out  1  pop strobe to the data register.
- o_Overrun  out  1  sticky overrun flag.
- o_Frame_err  out  1  sticky framing-error flag.
- o_Parity_err  out  1  sticky parity-error flag.
- o_Busy  out  1  frame in progress (state != IDLE).
- o_Irq  out  1  registered interrupt output.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift register 0, bit counter 0, synchronisers 0.
- Edge detect: a sample tick is one i_Pclk cycle after a 0->1 transition of synchronised i_Sclk; i_Rxd is taken from the same synchroniser stage. Tick latency from the i_Sclk edge is SYNC_STAGES+1 cycles.
- FSM states and transitions:
  - IDLE: on a tick with Rxd=0 and i_En=1 -> DATA, bit counter cleared.
  - DATA: each tick shifts Rxd into bit [count], count++. After DATA_BITS ticks -> PARITY if PARITY_EN, else STOP.
  - PARITY: on a tick, compare Rxd with the computed parity (XOR of data bits, inverted if PARITY_ODD). On mismatch set o_Parity_err and remember a bad frame -> STOP.
  - STOP: on a tick with Rxd=0, set o_Frame_err and mark the frame bad -> DELIVER.
  - DELIVER: lasts one cycle unless deferred (see below), then -> IDLE.
- DELIVER rules, evaluated in order:
  - Bad frame: no push; byte discarded.
  - i_Rd=1 this cycle: o_Pop=1, stay in DELIVER one more cycle. This avoids a simultaneous push/pop, where the register's pop would clear the new data's full flag.
  - i_Full=1: set o_Overrun; byte discarded; no push.
  - Otherwise: o_Push=1 for exactly one cycle, with o_Data valid in that cycle.
- o_Pop = i_Rd & i_Full, combinational, in every state.
- i_En low, in any state: FSM -> IDLE on the next cycle; partial frame dropped; no push; error flags kept.
- Sticky flags: set only by the events above; cleared by i_Clr_err. If set and clear happen in the same cycle, set wins.
- o_Irq is registered: (i_Rx_ie & i_Full) | (i_Err_ie & (o_Overrun | o_Frame_err | o_Parity_err)).
- A tick arriving while in DELIVER is impossible, given i_Sclk <= i_Pclk/4 and at most one deferral cycle.

Decomposition:
- Shared package usrt_pkg holds:
  - FSM state encoding: IDLE, DATA, PARITY, STOP, DELIVER.
  - DATA_BITS range constants.
  - Parity-select constants.
- One sub-module is natural: usrt_sync_edge. It contains the SYNC_STAGES synchroniser for Sclk/Rxd and the rising-edge tick generator, and is reused by the Tx controller.

Test Plan:
- Frame 0xA5, even parity bit 0, stop 1, i_Full=0 -> exactly one o_Push with o_Data=0xA5; no error flags; o_Irq=1 once i_Full rises with i_Rx_ie=1.
- Same frame with the parity bit flipped to 1 -> o_Parity_err=1, no o_Push; i_Clr_err pulse -> flag returns to 0.
- Frame 0x3C with stop bit 0 -> o_Frame_err=1, no o_Push, FSM returns to IDLE, o_Busy=0.
- i_Full=1, frame 0x11 received, i_Rd=0 -> o_Overrun=1, no o_Push; with i_Err_ie=1, o_Irq=1.
- i_Full=1, i_Rd asserted in the first DELIVER cycle -> o_Pop=1 in that cycle, then o_Push with 0x11 one cycle later, no overrun.
- i_En dropped after 4 data bits of a frame -> FSM to IDLE next cycle, no o_Push. Reset pulsed mid-frame -> all outputs 0 immediately, asynchronously.
